// File: rtl/simple_dp_mem_pkg.sv
`default_nettype none
// =============================================================================
// simple_dp_mem_pkg : default geometry and word/address types for simple_dp_mem
// Revision: 1.0
// =============================================================================
package simple_dp_mem_pkg;

  localparam int unsigned c_DATA_W = 16;
  localparam int unsigned c_ADDR_W = 10;
  localparam int unsigned c_DEPTH  = 2 ** c_ADDR_W;

  typedef logic [c_DATA_W-1:0] data_t;
  typedef logic [c_ADDR_W-1:0] addr_t;

endpackage : simple_dp_mem_pkg
`default_nettype wire

// File: rtl/simple_dp_mem_array.sv
`default_nettype none
// =============================================================================
// simple_dp_mem_array : storage array, synchronous write port, unregistered read
// Revision: 1.0
// =============================================================================
module simple_dp_mem_array
  import simple_dp_mem_pkg::*;
#(
  parameter int unsigned DATA_W = c_DATA_W,
  parameter int unsigned ADDR_W = c_ADDR_W,
  parameter int unsigned DEPTH  = c_DEPTH
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_adr,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic [ADDR_W-1:0] rd_adr,
  output logic [DATA_W-1:0] rd_dat
);

  // No reset on the array so it maps onto block RAM; contents start undefined.
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_adr] <= wr_dat;
    end
  end

  assign rd_dat = mem_q[rd_adr];

endmodule : simple_dp_mem_array
`default_nettype wire

// File: rtl/simple_dp_mem.sv
`default_nettype none
// =============================================================================
// simple_dp_mem : dual-port RAM, registered read. SIMPLE_DP_MEM_BYPASS_EN
// selects write-first on same-address collision (default read-first).
// Revision: 1.0
// =============================================================================
module simple_dp_mem
  import simple_dp_mem_pkg::*;
#(
  parameter int unsigned DATA_W = c_DATA_W,
  parameter int unsigned ADDR_W = c_ADDR_W,
  parameter int unsigned DEPTH  = c_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] dat_in,
  input  logic [ADDR_W-1:0] wr_adr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] rd_adr,
  output logic [DATA_W-1:0] dat_out
);

`ifdef SIMPLE_DP_MEM_BYPASS_EN
  localparam bit c_BYPASS = 1'b1;
`else
  localparam bit c_BYPASS = 1'b0;
`endif

  logic              w_wr_in_range;
  logic              w_rd_in_range;
  logic              w_we;
  logic              w_collision;
  logic [DATA_W-1:0] w_rd_dat;
  logic [DATA_W-1:0] dat_out_d;
  logic [DATA_W-1:0] dat_out_q;

  if (DEPTH < (2 ** ADDR_W)) begin : g_range_chk
    assign w_wr_in_range = (32'(wr_adr) < DEPTH);
    assign w_rd_in_range = (32'(rd_adr) < DEPTH);
  end else begin : g_full_range
    assign w_wr_in_range = 1'b1;
    assign w_rd_in_range = 1'b1;
  end

  // Writes are gated by reset so an asserted rst_n freezes the array.
  assign w_we        = wr_en & rst_n & w_wr_in_range;
  assign w_collision = w_we & (wr_adr == rd_adr);

  simple_dp_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk    (clk),
    .we     (w_we),
    .wr_adr (wr_adr),
    .wr_dat (dat_in),
    .rd_adr (rd_adr),
    .rd_dat (w_rd_dat)
  );

  always_comb begin
    dat_out_d = w_rd_dat;
    if (!w_rd_in_range) begin
      dat_out_d = '0;
    end else if (c_BYPASS && w_collision) begin
      dat_out_d = dat_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat_out_q <= '0;
    end else begin
      dat_out_q <= dat_out_d;
    end
  end

  assign dat_out = dat_out_q;

endmodule : simple_dp_mem
`default_nettype wire

// File: tb/tb_simple_dp_mem.sv
`default_nettype none
// =============================================================================
// tb_simple_dp_mem : scoreboard bench for simple_dp_mem against an array model
// Revision: 1.0
// =============================================================================
module tb_simple_dp_mem;

  logic        clk;
  logic        rst_n;
  logic [15:0] dat_in;
  logic [9:0]  wr_adr;
  logic        wr_en;
  logic [9:0]  rd_adr;
  logic [15:0] dat_out;

  simple_dp_mem dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .dat_in  (dat_in),
    .wr_adr  (wr_adr),
    .wr_en   (wr_en),
    .rd_adr  (rd_adr),
    .dat_out (dat_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SIMPLE_DP_MEM_BYPASS_EN
  localparam bit c_WRITE_FIRST = 1'b1;
`else
  localparam bit c_WRITE_FIRST = 1'b0;
`endif

  typedef struct {
    bit          known;
    bit [15:0]   v;
    int          id;
    bit [9:0]    adr;
  } exp_t;

  exp_t        sb_q[$];
  bit [15:0]   model_mem [int];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          rd_id   = 0;

  // Behavioural model: a word is known once written; a collision yields the
  // new data when write-first, the previous word otherwise.
  task automatic cycle(input bit we, input bit [9:0] wa, input bit [15:0] d,
                       input bit [9:0] ra);
    exp_t e;
    wr_en  = we;
    wr_adr = wa;
    dat_in = d;
    rd_adr = ra;
    e.id   = rd_id++;
    e.adr  = ra;
    if (we && wa == ra && c_WRITE_FIRST) begin
      e.known = 1'b1;
      e.v     = d;
    end else if (model_mem.exists(int'(ra))) begin
      e.known = 1'b1;
      e.v     = model_mem[int'(ra)];
    end else begin
      e.known = 1'b0;
      e.v     = '0;
    end
    sb_q.push_back(e);
    if (we) model_mem[int'(wa)] = d;
    @(negedge clk);
  endtask

  // Reset pulse with a write attempt to 2AA that must be blocked.
  task automatic reset_pulse();
    #2;
    rst_n  = 1'b0;
    wr_en  = 1'b1;
    wr_adr = 10'h2AA;
    dat_in = 16'hDEAD;
    rd_adr = 10'h2AA;
    #1;
    n_tests++;
    if (dat_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_async: dat_out=%h expected=0000", dat_out);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (dat_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_hold: dat_out=%h expected=0000", dat_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.known) begin
          n_tests++;
          if (dat_out !== e.v) begin
            n_fail++;
            $display("FAIL read#%0d adr=%h: dat_out=%h expected=%h",
                     e.id, e.adr, dat_out, e.v);
          end
        end
      end
    end
  end

  initial begin : driver
    bit [9:0] pool [8];
    int       budget;
    rst_n  = 1'b0;
    wr_en  = 1'b0;
    wr_adr = '0;
    dat_in = '0;
    rd_adr = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (dat_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_state: dat_out=%h expected=0000", dat_out);
    end
    rst_n = 1'b1;

    // Directed scenarios
    cycle(1'b1, 10'h2AA, 16'h000A, 10'h2AA);   // collision on an unknown word
    cycle(1'b0, 10'h000, 16'h0000, 10'h2AA);   // write-then-read
    cycle(1'b1, 10'h001, 16'hBEEF, 10'h2AA);   // independent ports
    cycle(1'b0, 10'h000, 16'h0000, 10'h001);
    cycle(1'b0, 10'h2AA, 16'hFFFF, 10'h2AA);   // wr_en low must not write
    cycle(1'b0, 10'h000, 16'h0000, 10'h2AA);
    reset_pulse();
    cycle(1'b0, 10'h000, 16'h0000, 10'h2AA);   // retention after reset
    cycle(1'b1, 10'h2AA, 16'h1234, 10'h2AA);   // collision with old word 000A
    cycle(1'b0, 10'h000, 16'h0000, 10'h2AA);
    cycle(1'b1, 10'h3FF, 16'h5A5A, 10'h001);   // top address
    cycle(1'b0, 10'h000, 16'h0000, 10'h3FF);

    // Randomized traffic over a small address pool to force collisions
    pool = '{10'h000, 10'h001, 10'h2AA, 10'h3FF, 10'h155, 10'h0F0, 10'h200, 10'h07E};
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 2) != 0),
            pool[$urandom_range(0, 7)],
            16'($urandom),
            pool[$urandom_range(0, 7)]);
      if (i == 200) reset_pulse();
    end
    wr_en = 1'b0;

    budget = 10;
    while (sb_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (sb_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d reads outstanding, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_simple_dp_mem
`default_nettype wire
